hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit owning the HI/LO architectural registers; successor to the single-cycle HI/LO path.
- Sits in EX beside the main ALU, supporting MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO at configurable data width.
- Long operations are multi-cycle; the unit drives Busy so the hazard logic can stall younger instructions.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst  input  1  asynchronous, active-high reset.
Start  input  1  request; accepted only when Busy=0.
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO.
A  input  WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO source).
B  input  WIDTH  rt operand (divisor/multiplier).
Cancel  input  1  flush; aborts the in-flight operation, HI/LO untouched.
Busy  output  1  registered; high while an iterative operation is in flight.
Done  output  1  one-cycle pulse after HI/LO commit or abort-by-zero.
DivByZero  output  1  one-cycle pulse coincident with Done for a zero-divisor DIV/DIVU.
Hi  output  WIDTH  HI register.
Lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, Rst=1): state IDLE; Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, counter=0, working registers cleared. Reset asserted mid-operation aborts it immediately.
- States: IDLE, RUN, FIX.
- IDLE:
  - Start with Op=MTHI/MTLO: Hi (resp. Lo) <= A at that edge. Done pulses next cycle. Busy stays 0.
  - Start with DIV/DIVU and B=0: no state change to Hi/Lo. Done and DivByZero pulse next cycle. Busy stays 0.
  - Other Start: latch operand magnitudes (signed ops take two's-complement absolute values) and result signs. Counter <= 0, Busy <= 1, go to RUN.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After WIDTH steps go to FIX.
- FIX: apply signs.
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Commit: MULT/MULTU gives {Hi,Lo} <= product. DIV/DIVU gives Lo <= quotient, Hi <= remainder. MADD gives {Hi,Lo} <= {Hi,Lo} + signed product; MSUB gives {Hi,Lo} <= {Hi,Lo} - signed product. Both wrap mod 2^(2*WIDTH).
  - Busy <= 0, Done <= 1, return to IDLE.
- Latency: Start accepted at edge N; Busy is high from after edge N through edge N+WIDTH+1. Hi/Lo update at edge N+WIDTH+1; Done is high in the following cycle. For WIDTH=32 that is 33 edges.
- Start while Busy=1 is ignored: no queueing, operands discarded.
- Cancel while Busy=1: return to IDLE next edge, Busy <= 0, no Done, Hi/Lo unchanged.
- Cancel and Start in the same cycle while IDLE: Cancel wins; nothing is accepted.
- DIV of most-negative by -1: quotient wraps to most-negative, remainder 0, no flag.
- Hi/Lo change only at a FIX commit or an MTHI/MTLO accept. Outputs read combinationally from the registers.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in RUN for MULT/MULTU/MADD/MSUB, when the remaining unshifted multiplier bits are all zero, jump directly to FIX. Minimum latency is 2 edges (one RUN step plus FIX). Divide latency is unchanged.
- Undefined: every iterative operation takes exactly WIDTH RUN steps plus FIX.
- Results are identical in both builds; only Busy/Done timing differs.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, WIDTH=32 -> Hi=0xFFFFFFFE, Lo=0x00000001 at edge N+33; Busy high 33 cycles; single Done pulse.
2. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); MULT A=-3, B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
3. DIVU A=0x1234, B=0 with Hi/Lo preloaded via MTHI 0xAAAA / MTLO 0x5555 -> Done and DivByZero pulse one cycle later; Hi=0xAAAA, Lo=0x5555; Busy never rises.
4. MTLO 0xFFFFFFFF, MTHI 0, then MADD A=1, B=1 -> Hi=0x00000001, Lo=0x00000000. Then MSUB A=1, B=1 -> Hi=0, Lo=0xFFFFFFFF.
5. Abort paths:
   - MULT started, Start with DIV issued at step 5 -> ignored; MULT result commits.
   - Cancel at step 10 -> Busy drops next cycle, no Done, Hi/Lo unchanged.
   - Rst pulse mid-RUN -> all outputs 0 immediately.
6. With MULDIV_EARLY_OUT_EN: MULTU A=7, B=1 -> Hi=0, Lo=7, Done 2 cycles after accept. Without it: same values at edge N+33.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN ends multiplies early once the remaining multiplier bits are zero.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d, dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               negRes_q, negRes_d, negRem_q, negRem_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic               signedOp, runIsDiv;
    logic [WIDTH-1:0]   aMag, bMag, quoSigned, remSigned;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prodSigned, hiloCur;

    assign signedOp   = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign aMag       = (signedOp && A[WIDTH-1]) ? -A : A;
    assign bMag       = (signedOp && B[WIDTH-1]) ? -B : B;
    assign runIsDiv   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    // Restoring divide: a borrow in the trial subtraction means the divisor did not fit.
    assign trial      = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
    assign prodSigned = negRes_q ? -acc_q : acc_q;
    assign quoSigned  = negRes_q ? -quo_q : quo_q;
    assign remSigned  = negRem_q ? -rem_q : rem_q;
    assign hiloCur    = {hi_q, lo_q};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start && !Cancel) begin
                    if (Op == OP_MTHI) begin
                        hi_d   = A;
                        done_d = 1'b1;
                    end else if (Op == OP_MTLO) begin
                        lo_d   = A;
                        done_d = 1'b1;
                    end else if (((Op == OP_DIV) || (Op == OP_DIVU)) && (B == '0)) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        op_d     = Op;
                        negRes_d = signedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
                        negRem_d = signedOp && A[WIDTH-1];
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, aMag};
                        mplier_d = bMag;
                        dvsr_d   = bMag;
                        rem_d    = '0;
                        quo_d    = aMag;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (Cancel) begin
                    state_d = IDLE;
                end else begin
                    if (runIsDiv) begin
                        if (!trial[WIDTH]) begin
                            rem_d = trial[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                            quo_d = {quo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if (!runIsDiv && ((mplier_q >> 1) == '0)) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            FIX: begin
                if (Cancel) begin
                    state_d = IDLE;
                end else begin
                    case (op_q)
                        OP_DIV, OP_DIVU: begin
                            lo_d = quoSigned;
                            hi_d = remSigned;
                        end
                        OP_MADD: {hi_d, lo_d} = hiloCur + prodSigned;
                        OP_MSUB: {hi_d, lo_d} = hiloCur - prodSigned;
                        default: {hi_d, lo_d} = prodSigned;
                    endcase
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: scoreboard of expected HI/LO results, latency and flags.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst, Start, Cancel;
    logic [2:0]   Op;
    logic [W-1:0] A, B;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] Hi, Lo;

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Cancel(Cancel),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        bit           iter;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mHi = '0, mLo = '0;
    int           vectors = 0, miscompares = 0;
    int           acceptCyc = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected number of edges from accept to commit.
    function automatic int expLatency(input logic [2:0] op, input logic [W-1:0] b);
        logic [W-1:0] mag;
        int           steps;
        if (op == 3'b110 || op == 3'b111) return 0;
        if (op == 3'b010 || op == 3'b011) return (b == '0) ? 0 : W + 1;
`ifdef MULDIV_EARLY_OUT_EN
        mag   = (op != 3'b001 && b[W-1]) ? -b : b;
        steps = 1;
        for (int i = 0; i < W; i++) if (mag[i]) steps = i + 1;
        return steps + 1;
`else
        mag   = b;
        steps = W;
        return steps + 1;
`endif
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit track);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sbv;
        if (track) begin
            e.dbz  = 1'b0;
            e.iter = 1'b1;
            sa     = longint'($signed(a));
            sbv    = longint'($signed(b));
            case (op)
                3'b000: {mHi, mLo} = 64'(sa * sbv);
                3'b001: {mHi, mLo} = {32'b0, a} * {32'b0, b};
                3'b010: if (b == '0) begin e.dbz = 1'b1; e.iter = 1'b0; end
                        else begin mLo = 32'(sa / sbv); mHi = 32'(sa % sbv); end
                3'b011: if (b == '0) begin e.dbz = 1'b1; e.iter = 1'b0; end
                        else begin mLo = a / b; mHi = a % b; end
                3'b100: begin p = 64'(sa * sbv); {mHi, mLo} = {mHi, mLo} + p; end
                3'b101: begin p = 64'(sa * sbv); {mHi, mLo} = {mHi, mLo} - p; end
                3'b110: begin mHi = a; e.iter = 1'b0; end
                default: begin mLo = a; e.iter = 1'b0; end
            endcase
            e.hi  = mHi;
            e.lo  = mLo;
            e.lat = expLatency(op, b);
            sb.push_back(e);
        end
        @(negedge Clk);
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        acceptCyc = cyc;
    endtask

    task automatic waitDone(input string tag);
        exp_t e;
        int   busyBad = 0;
        bit   seen = 0;
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL %s scoreboard empty observed=0 expected=1 entry", tag);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < 200; k++) begin
            if (Done === 1'b1) begin seen = 1; break; end
            if (Busy !== e.iter) busyBad++;
            @(negedge Clk);
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("[TB] FAIL %s timeout observed=no_done expected=done", tag);
            return;
        end
        checkOutput({tag, " latency"}, cyc - acceptCyc, e.lat);
        checkOutput({tag, " hi"}, Hi, e.hi);
        checkOutput({tag, " lo"}, Lo, e.lo);
        checkOutput({tag, " dbz"}, DivByZero, e.dbz);
        checkOutput({tag, " busyAtDone"}, Busy, 0);
        checkOutput({tag, " busyWhileRun"}, busyBad, 0);
        @(negedge Clk);
        checkOutput({tag, " donePulse"}, Done, 0);
    endtask

    initial begin
        int doneCount;
        Rst = 1'b1; Start = 1'b0; Cancel = 1'b0; Op = '0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        checkOutput("reset hi", Hi, 0);
        checkOutput("reset lo", Lo, 0);
        checkOutput("reset busy", Busy, 0);
        checkOutput("reset done", Done, 0);
        checkOutput("reset dbz", DivByZero, 0);
        Rst = 1'b0;

        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        waitDone("multu max");
        checkOutput("multu max hi lit", Hi, 32'hFFFFFFFE);
        checkOutput("multu max lo lit", Lo, 32'h00000001);

        applyStimulus(3'b010, 32'hFFFFFFF9, 32'd2, 1);
        waitDone("div -7/2");
        checkOutput("div -7/2 lit", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);

        applyStimulus(3'b000, 32'hFFFFFFFD, 32'd5, 1);
        waitDone("mult -3*5");
        checkOutput("mult -3*5 lit", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);

        applyStimulus(3'b110, 32'h0000AAAA, 32'd0, 1);
        waitDone("mthi");
        applyStimulus(3'b111, 32'h00005555, 32'd0, 1);
        waitDone("mtlo");
        applyStimulus(3'b011, 32'h00001234, 32'd0, 1);
        waitDone("divu by zero");
        checkOutput("divu by zero lit", {Hi, Lo}, 64'h0000AAAA_00005555);

        applyStimulus(3'b111, 32'hFFFFFFFF, 32'd0, 1);
        waitDone("mtlo ones");
        applyStimulus(3'b110, 32'h0, 32'd0, 1);
        waitDone("mthi zero");
        applyStimulus(3'b100, 32'd1, 32'd1, 1);
        waitDone("madd carry");
        checkOutput("madd carry lit", {Hi, Lo}, 64'h00000001_00000000);
        applyStimulus(3'b101, 32'd1, 32'd1, 1);
        waitDone("msub borrow");
        checkOutput("msub borrow lit", {Hi, Lo}, 64'h00000000_FFFFFFFF);

        applyStimulus(3'b010, 32'h80000000, 32'hFFFFFFFF, 1);
        waitDone("div minneg/-1");
        checkOutput("div minneg/-1 lit", {Hi, Lo}, 64'h00000000_80000000);
        applyStimulus(3'b010, 32'd7, 32'hFFFFFFFE, 1);
        waitDone("div 7/-2");
        checkOutput("div 7/-2 lit", {Hi, Lo}, 64'h00000001_FFFFFFFD);
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'd7, 1);
        waitDone("divu big/7");
        applyStimulus(3'b100, 32'hFFFFFFFE, 32'd3, 1);
        waitDone("madd -2*3");

        // A second Start while busy must be dropped without disturbing the running MULT.
        applyStimulus(3'b000, 32'd12345, 32'hFFFFFD5A, 1);
        repeat (4) @(negedge Clk);
        Op = 3'b010; A = 32'd100; B = 32'd3; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        waitDone("mult with ignored start");

        applyStimulus(3'b001, 32'h01234567, 32'hF0F0F0F1, 0);
        repeat (9) @(negedge Clk);
        Cancel = 1'b1;
        @(negedge Clk);
        Cancel = 1'b0;
        checkOutput("cancel busy drop", Busy, 0);
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) doneCount++;
            @(negedge Clk);
        end
        checkOutput("cancel no done", doneCount, 0);
        checkOutput("cancel hilo kept", {Hi, Lo}, {mHi, mLo});

        Op = 3'b110; A = 32'hDEADBEEF; Start = 1'b1; Cancel = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Cancel = 1'b0;
        checkOutput("idle cancel wins hi", Hi, mHi);
        checkOutput("idle cancel wins done", Done, 0);
        Op = 3'b001; A = 32'd9; B = 32'd9; Start = 1'b1; Cancel = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Cancel = 1'b0;
        checkOutput("idle cancel wins busy", Busy, 0);

        applyStimulus(3'b001, 32'd7, 32'd1, 1);
        waitDone("multu 7*1");
        checkOutput("multu 7*1 lit", {Hi, Lo}, 64'h00000000_00000007);

        applyStimulus(3'b001, 32'h00010001, 32'hFFFF0001, 0);
        repeat (5) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        checkOutput("midrun reset hilo", {Hi, Lo}, 64'h0);
        checkOutput("midrun reset flags", {Busy, Done, DivByZero}, 3'b000);
        @(negedge Clk);
        Rst = 1'b0;
        mHi = '0; mLo = '0;
        applyStimulus(3'b111, 32'h13579BDF, 32'd0, 1);
        waitDone("mtlo after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
